// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receiver.
//   rx_state_e      : receiver FSM state encoding (3-bit register)
//   COUNT_REG_LEN   : width of the bit-period cycle counter
//   cycles_per_bit(): clk cycles per serial bit, using integer ns periods
package uart_rx_pkg;

  localparam int COUNT_REG_LEN = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    STOP  = 3'd3
  } rx_state_e;

  // Bit period and clock period are both truncated to whole ns before
  // dividing, so the result matches the transmitter's derivation exactly.
  function automatic int cycles_per_bit(input int bit_rate, input int clk_mhz);
    int bit_p;
    int clk_p;
    bit_p = 1_000_000_000 / bit_rate;
    clk_p = 1000 / clk_mhz;
    return bit_p / clk_p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
//   clk    : system clock
//   resetn : asynchronous active-low reset (both flops reset to 1 = line idle)
//   d      : raw serial input
//   q      : synchronised serial input
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, LSB first, configurable payload and stop bits.
//   clk           : system clock
//   resetn        : asynchronous active-low reset
//   uart_rxd      : serial line, idle high
//   uart_rx_en    : accept new start bits while high (frames in flight finish)
//   uart_rx_busy  : high whenever the FSM is outside IDLE
//   uart_rx_valid : 1-cycle pulse, frame received with good stop bit(s)
//   uart_rx_data  : last good payload, right-aligned, held between frames
//   uart_rx_ferr  : 1-cycle pulse, a stop bit was sampled low
//   uart_rx_break : 1-cycle pulse alongside uart_rx_ferr when the payload was 0
//
// The output side is a plain pulse interface with no back-pressure: a
// valid/ferr pulse is offered for exactly one cycle and the consumer must
// capture it then; uart_rx_data stays stable until the next good frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_MHZ      = 50,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_break
);

  localparam int CPB_I = cycles_per_bit(BIT_RATE, CLK_MHZ);
  localparam logic [COUNT_REG_LEN-1:0] CPB      = COUNT_REG_LEN'(CPB_I);
  localparam logic [COUNT_REG_LEN-1:0] HALF_BIT = COUNT_REG_LEN'(CPB_I / 2);
  localparam logic [2:0]               LAST_BIT = 3'(PAYLOAD_BITS - 1);
  localparam logic                     LAST_STOP = 1'(STOP_BITS - 1);

  logic                     rxd_s;
  rx_state_e                state;
  logic [COUNT_REG_LEN-1:0] cnt;
  logic [2:0]               bit_cnt;
  logic                     stop_cnt;
  logic                     stop_err;
  logic                     wait_high;
  logic [PAYLOAD_BITS-1:0]  shift;
  logic [PAYLOAD_BITS:0]    shift_ext;

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  // New bit enters at the MSB; after PAYLOAD_BITS shifts bit 0 sits in bit 0.
  // Built via a widened vector so PAYLOAD_BITS=1 needs no special case.
  assign shift_ext    = {rxd_s, shift};
  assign uart_rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      stop_err      <= 1'b0;
      wait_high     <= 1'b0;
      shift         <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
      uart_rx_break <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          stop_err <= 1'b0;
          // After a frame error the line must be seen high again, otherwise
          // a held-low break would retrigger a frame every bit time.
          if (rxd_s) wait_high <= 1'b0;
          if (uart_rx_en && !rxd_s && !wait_high) state <= START;
        end
        START: begin
          if (cnt == HALF_BIT) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : RECV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECV: begin
          if (cnt == CPB) begin
            // Reload to 1 so later samples are spaced exactly CPB apart.
            cnt   <= COUNT_REG_LEN'(1);
            shift <= shift_ext[PAYLOAD_BITS:1];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CPB) begin
            cnt <= COUNT_REG_LEN'(1);
            if (stop_cnt == LAST_STOP) begin
              state <= IDLE;
              if (stop_err || !rxd_s) begin
                uart_rx_ferr  <= 1'b1;
                uart_rx_break <= (shift == '0);
                wait_high     <= 1'b1;
              end else begin
                uart_rx_data  <= shift;
                uart_rx_valid <= 1'b1;
              end
            end else begin
              stop_cnt <= 1'b1;
              stop_err <= stop_err | ~rxd_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
